// File: rtl/envase_sequencer.sv
// Bottling-station controller: conveyor, fill valve and capper sequencing, bottle/cork counter strobes, box tracking, alarms.
// Optional FILL_WATCHDOG_EN: when defined, a bottle that does not reach level_full within FILL_TIMEOUT cycles raises alarm code 01.
module envase_sequencer #(
  parameter int FILL_TIMEOUT = 64,
  parameter int SEAL_CYCLES  = 4,
  parameter int BATCH_SIZE   = 12,
  parameter int DISP_MAX     = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       bottle_present,
  input  logic       level_full,
  input  logic       ack,
  input  logic       refill_req,
  input  logic [7:0] refill_qty,
  input  logic [7:0] cork_count,
  output logic       motor_on,
  output logic       valve_open,
  output logic       seal_on,
  output logic       cnt_inc,
  output logic       disp_dec,
  output logic       disp_load,
  output logic [7:0] disp_data,
  output logic       batch_done,
  output logic [7:0] batch_count,
  output logic       alarm,
  output logic [1:0] alarm_code,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CONVEY = 3'd1;
  localparam logic [2:0] S_FILL   = 3'd2;
  localparam logic [2:0] S_SEAL   = 3'd3;
  localparam logic [2:0] S_COUNT  = 3'd4;
  localparam logic [2:0] S_ALARM  = 3'd5;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_EMPTY   = 2'b10;

  logic [2:0] cur_state, nxt_state;
  logic [3:0] seal_cnt;
  logic       stop_latch;
  logic       alarm_set;
  logic [1:0] alarm_val;
  logic [1:0] code_r;
  logic [7:0] batch_r;
  logic       load_r;
  logic [7:0] data_r;
  logic       fill_expired;
  logic       seal_last;
  logic       batch_last;

  // Room left in the dispenser, computed wide and signed so an overfull dispenser yields 0.
  function automatic logic [7:0] refill_amount(input logic [7:0] qty, input logic [7:0] level);
    logic signed [9:0] room;
    logic signed [9:0] offer;
    room  = $signed(10'(DISP_MAX)) - $signed({2'b00, level});
    offer = $signed({2'b00, qty});
    if (room <= 10'sd0)
      return 8'd0;
    else if (offer > room)
      return room[7:0];
    else
      return qty;
  endfunction

`ifdef FILL_WATCHDOG_EN
  logic [7:0] fill_timer;

  always_ff @(posedge clk) begin
    if (reset || cur_state != S_FILL)
      fill_timer <= 8'd0;
    else
      fill_timer <= fill_timer + 8'd1;
  end

  assign fill_expired = (fill_timer == 8'(FILL_TIMEOUT - 1));
`else
  assign fill_expired = 1'b0;
`endif

  assign seal_last  = (seal_cnt == 4'(SEAL_CYCLES - 1));
  assign batch_last = (batch_r == 8'(BATCH_SIZE - 1));

  always_ff @(posedge clk) begin
    if (reset)
      cur_state <= S_IDLE;
    else
      cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    alarm_set = 1'b0;
    alarm_val = CODE_NONE;
    case (cur_state)
      S_IDLE: begin
        if (start && !stop) begin
          if (cork_count != 8'd0) begin
            nxt_state = S_CONVEY;
          end else begin
            nxt_state = S_ALARM;
            alarm_set = 1'b1;
            alarm_val = CODE_EMPTY;
          end
        end
      end
      S_CONVEY: begin
        if (stop)
          nxt_state = S_IDLE;
        else if (bottle_present)
          nxt_state = S_FILL;
      end
      S_FILL: begin
        if (level_full) begin
          nxt_state = S_SEAL;
        end else if (fill_expired) begin
          nxt_state = S_ALARM;
          alarm_set = 1'b1;
          alarm_val = CODE_TIMEOUT;
        end
      end
      S_SEAL: begin
        if (seal_last)
          nxt_state = S_COUNT;
      end
      S_COUNT: begin
        if (cork_count == 8'd0) begin
          nxt_state = S_ALARM;
          alarm_set = 1'b1;
          alarm_val = CODE_EMPTY;
        end else if (stop_latch) begin
          nxt_state = S_IDLE;
        end else begin
          nxt_state = S_CONVEY;
        end
      end
      S_ALARM: begin
        if (ack)
          nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seal_cnt   <= 4'd0;
      stop_latch <= 1'b0;
      code_r     <= CODE_NONE;
      batch_r    <= 8'd0;
      load_r     <= 1'b0;
      data_r     <= 8'd0;
    end else begin
      seal_cnt <= (cur_state == S_SEAL) ? seal_cnt + 4'd1 : 4'd0;

      // A halt requested mid-bottle is remembered until that bottle is counted.
      if (cur_state == S_COUNT || cur_state == S_ALARM)
        stop_latch <= 1'b0;
      else if ((cur_state == S_FILL || cur_state == S_SEAL) && stop)
        stop_latch <= 1'b1;

      if (alarm_set)
        code_r <= alarm_val;
      else if (cur_state == S_ALARM && ack)
        code_r <= CODE_NONE;

      if (cur_state == S_COUNT)
        batch_r <= batch_last ? 8'd0 : batch_r + 8'd1;

      if (refill_req && (cur_state == S_IDLE || cur_state == S_ALARM)) begin
        load_r <= 1'b1;
        data_r <= refill_amount(refill_qty, cork_count);
      end else begin
        load_r <= 1'b0;
        data_r <= 8'd0;
      end
    end
  end

  always_comb begin
    motor_on   = (cur_state == S_CONVEY);
    valve_open = (cur_state == S_FILL);
    seal_on    = (cur_state == S_SEAL);
    disp_dec   = (cur_state == S_SEAL) && (seal_cnt == 4'd0);
    cnt_inc    = (cur_state == S_COUNT);
    batch_done = (cur_state == S_COUNT) && batch_last;
    alarm      = (cur_state == S_ALARM);
  end

  assign alarm_code  = code_r;
  assign batch_count = batch_r;
  assign disp_load   = load_r;
  assign disp_data   = data_r;
  assign state       = cur_state;

endmodule

// File: tb/tb_envase_sequencer.sv
// Directed bench for envase_sequencer with default parameters; watchdog expectations follow FILL_WATCHDOG_EN.
module tb_envase_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stop, bottle_present, level_full, ack, refill_req;
  logic [7:0] refill_qty, cork_count;
  logic       motor_on, valve_open, seal_on, cnt_inc, disp_dec, disp_load;
  logic [7:0] disp_data;
  logic       batch_done;
  logic [7:0] batch_count;
  logic       alarm;
  logic [1:0] alarm_code;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  envase_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .bottle_present(bottle_present), .level_full(level_full), .ack(ack),
    .refill_req(refill_req), .refill_qty(refill_qty), .cork_count(cork_count),
    .motor_on(motor_on), .valve_open(valve_open), .seal_on(seal_on),
    .cnt_inc(cnt_inc), .disp_dec(disp_dec), .disp_load(disp_load),
    .disp_data(disp_data), .batch_done(batch_done), .batch_count(batch_count),
    .alarm(alarm), .alarm_code(alarm_code), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {motor_on, valve_open, seal_on, cnt_inc, disp_dec, disp_load,
            disp_data, batch_done, batch_count, alarm, alarm_code, state};
  endfunction

  // Runs one bottle starting in CONVEY; returns batch_done as seen in COUNT.
  task automatic do_bottle(output logic done);
    bottle_present = 1'b1;
    tick();
    bottle_present = 1'b0;
    level_full = 1'b1;
    tick();
    level_full = 1'b0;
    repeat (3) tick();
    tick();
    done = batch_done;
    tick();
  endtask

  initial begin
    logic done;
    int   n_done;
    int   last_idx;

    reset = 1'b1; start = 1'b0; stop = 1'b0; bottle_present = 1'b0;
    level_full = 1'b0; ack = 1'b0; refill_req = 1'b0; refill_qty = 8'd0;
    cork_count = 8'd100;
    tick();
    tick();
    reset = 1'b0;
    check_eq("reset_outputs", all_outs(), 32'd0);

    // Start and stop together keeps the line idle.
    start = 1'b1; stop = 1'b1;
    tick();
    check_eq("start_stop_idle", state, 0);
    stop = 1'b0;

    // Normal bottle: start at 0, bottle at 3, level at 6.
    tick();
    check_eq("c1_convey", state, 1);
    check_eq("c1_motor", motor_on, 1);
    start = 1'b0;
    tick(); tick();
    bottle_present = 1'b1;
    tick();
    bottle_present = 1'b0;
    check_eq("c4_fill", state, 2);
    check_eq("c4_valve", valve_open, 1);
    tick(); tick();
    level_full = 1'b1;
    tick();
    level_full = 1'b0;
    check_eq("c7_seal", state, 3);
    check_eq("c7_disp_dec", disp_dec, 1);
    tick();
    check_eq("c8_no_dec", disp_dec, 0);
    check_eq("c8_seal_on", seal_on, 1);
    tick(); tick();
    check_eq("c10_seal", state, 3);
    tick();
    check_eq("c11_count", state, 4);
    check_eq("c11_cnt_inc", cnt_inc, 1);
    check_eq("c11_no_batch", batch_done, 0);
    tick();
    check_eq("c12_convey", state, 1);
    check_eq("c12_batch", batch_count, 1);

    // Eleven more bottles complete the box of twelve.
    n_done = 0; last_idx = -1;
    for (int i = 2; i <= 12; i++) begin
      do_bottle(done);
      if (done) begin
        n_done++;
        last_idx = i;
      end
    end
    check_eq("batch_done_count", n_done, 1);
    check_eq("batch_done_on_12", last_idx, 12);
    check_eq("batch_wrapped", batch_count, 0);

    // Dispenser empty at COUNT.
    bottle_present = 1'b1;
    tick();
    bottle_present = 1'b0; level_full = 1'b1;
    tick();
    level_full = 1'b0; cork_count = 8'd0;
    repeat (4) tick();
    tick();
    check_eq("empty_alarm_state", state, 5);
    check_eq("empty_alarm", alarm, 1);
    check_eq("empty_code", alarm_code, 2);
    check_eq("alarm_keeps_batch", batch_count, 1);

    refill_req = 1'b1; refill_qty = 8'd250;
    tick();
    refill_req = 1'b0;
    check_eq("refill_load_0", disp_load, 1);
    check_eq("refill_data_0", disp_data, 200);
    tick();
    check_eq("refill_load_off", disp_load, 0);
    cork_count = 8'd190; refill_req = 1'b1;
    tick();
    refill_req = 1'b0;
    check_eq("refill_data_190", disp_data, 10);
    cork_count = 8'd210; refill_req = 1'b1;
    tick();
    refill_req = 1'b0;
    check_eq("refill_load_full", disp_load, 1);
    check_eq("refill_data_full", disp_data, 0);

    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("ack_idle", state, 0);
    check_eq("ack_code", alarm_code, 0);

    // Start with an empty dispenser alarms straight from IDLE.
    cork_count = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("idle_empty_code", alarm_code, 2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    cork_count = 8'd100;

    // Refill in CONVEY is ignored.
    start = 1'b1;
    tick();
    start = 1'b0; refill_req = 1'b1; refill_qty = 8'd5;
    tick();
    refill_req = 1'b0;
    check_eq("refill_ignored", disp_load, 0);

    // Stop pulsed in FILL: bottle still finishes, then IDLE.
    bottle_present = 1'b1;
    tick();
    bottle_present = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0; level_full = 1'b1;
    tick();
    level_full = 1'b0;
    check_eq("stop_fill_seal", state, 3);
    repeat (3) tick();
    tick();
    check_eq("stop_fill_count", state, 4);
    tick();
    check_eq("stop_fill_idle", state, 0);

    // Stop in CONVEY beats bottle_present.
    start = 1'b1;
    tick();
    start = 1'b0; stop = 1'b1; bottle_present = 1'b1;
    tick();
    stop = 1'b0; bottle_present = 1'b0;
    check_eq("stop_convey_idle", state, 0);

    // Fill without level_full.
    start = 1'b1;
    tick();
    start = 1'b0; bottle_present = 1'b1;
    tick();
    bottle_present = 1'b0;
`ifdef FILL_WATCHDOG_EN
    repeat (63) tick();
    check_eq("wd_fill_64", state, 2);
    tick();
    check_eq("wd_alarm", state, 5);
    check_eq("wd_code", alarm_code, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("wd_ack_idle", state, 0);
    check_eq("wd_ack_code", alarm_code, 0);
`else
    repeat (1000) tick();
    check_eq("nowd_still_fill", state, 2);
    check_eq("nowd_no_code", alarm_code, 0);
`endif

    // Reset during the second SEAL cycle.
    start = 1'b1;
    if (state == 3'd2) start = 1'b0;
    if (state == 3'd0) begin
      tick();
      start = 1'b0;
      bottle_present = 1'b1;
      tick();
      bottle_present = 1'b0;
    end
    start = 1'b0;
    level_full = 1'b1;
    tick();
    level_full = 1'b0;
    tick();
    check_eq("pre_reset_seal", state, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("reset_seal_state", state, 0);
    check_eq("reset_seal_on", seal_on, 0);
    check_eq("reset_batch", batch_count, 0);
    check_eq("reset_all_outs", all_outs(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
